rf_wb_arbiter: RTL and testbench

//  Shares the single register-file write port (we3/a3/wd3) between two writeback

---
 rtl/rf_wb_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Round-robin writeback arbiter: ALU and MEM {rd,data} FIFOs share one register-file write port; 2-cycle accept-to-write latency.
// Sources stall via x_ready when their FIFO is full; RF_WB_PERF_EN adds per-source saturating stall counters.

module rf_wb_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  output logic         push_rdy,
  input  logic         pop,
  output logic         head_vld,
  output logic [W-1:0] head_dat
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_fire, pop_fire;

  // Ready depends only on registered count, so a full FIFO never accepts in the
  // same cycle its head leaves; held low while reset is asserted.
  assign push_rdy  = rst_n && (cnt_q < DEPTH_C);
  assign head_vld  = (cnt_q != '0);
  assign head_dat  = mem_q[rd_ptr_q];
  assign push_fire = push_vld && push_rdy;
  assign pop_fire  = pop && head_vld;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_fire) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_fire) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_fire, pop_fire})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

module rf_wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            rf_we,
  output logic [4:0]      rf_wa,
  output logic [XLEN-1:0] rf_wd,
  output logic            idle
`ifdef RF_WB_PERF_EN
  ,
  output logic [15:0]     alu_stall_cnt,
  output logic [15:0]     mem_stall_cnt
`endif
);
  localparam int W = XLEN + 5;
  localparam logic GNT_ALU = 1'b0;
  localparam logic GNT_MEM = 1'b1;

  logic            alu_head_vld, mem_head_vld;
  logic [W-1:0]    alu_head_dat, mem_head_dat;
  logic            gnt_alu, gnt_mem;
  logic [W-1:0]    gnt_dat;
  logic            last_grant_q, last_grant_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_wa_q, rf_wa_d;
  logic [XLEN-1:0] rf_wd_q, rf_wd_d;

  rf_wb_fifo #(.W(W), .DEPTH(DEPTH)) u_alu_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (alu_valid),
    .push_dat ({alu_rd, alu_data}),
    .push_rdy (alu_ready),
    .pop      (gnt_alu),
    .head_vld (alu_head_vld),
    .head_dat (alu_head_dat)
  );

  rf_wb_fifo #(.W(W), .DEPTH(DEPTH)) u_mem_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (mem_valid),
    .push_dat ({mem_rd, mem_data}),
    .push_rdy (mem_ready),
    .pop      (gnt_mem),
    .head_vld (mem_head_vld),
    .head_dat (mem_head_dat)
  );

  // On a tie the source that did not win last time goes next.
  always_comb begin
    gnt_alu = alu_head_vld && (!mem_head_vld || (last_grant_q == GNT_MEM));
    gnt_mem = mem_head_vld && !gnt_alu;
    gnt_dat = gnt_alu ? alu_head_dat : mem_head_dat;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    rf_we_d      = 1'b0;
    rf_wa_d      = rf_wa_q;
    rf_wd_d      = rf_wd_q;
    if (gnt_alu || gnt_mem) begin
      last_grant_d = gnt_alu ? GNT_ALU : GNT_MEM;
      rf_wa_d      = gnt_dat[W-1:XLEN];
      rf_wd_d      = gnt_dat[XLEN-1:0];
      // x0 entries consume their slot but never write.
      rf_we_d      = (gnt_dat[W-1:XLEN] != 5'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= GNT_MEM;
      rf_we_q      <= 1'b0;
      rf_wa_q      <= 5'd0;
      rf_wd_q      <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rf_we_q      <= rf_we_d;
      rf_wa_q      <= rf_wa_d;
      rf_wd_q      <= rf_wd_d;
    end
  end

  assign rf_we = rf_we_q;
  assign rf_wa = rf_wa_q;
  assign rf_wd = rf_wd_q;
  assign idle  = !alu_head_vld && !mem_head_vld && !rf_we_q;

`ifdef RF_WB_PERF_EN
  logic [15:0] alu_stall_cnt_q, alu_stall_cnt_d;
  logic [15:0] mem_stall_cnt_q, mem_stall_cnt_d;

  always_comb begin
    alu_stall_cnt_d = alu_stall_cnt_q;
    mem_stall_cnt_d = mem_stall_cnt_q;
    if (alu_valid && !alu_ready && (alu_stall_cnt_q != 16'hFFFF)) begin
      alu_stall_cnt_d = alu_stall_cnt_q + 16'd1;
    end
    if (mem_valid && !mem_ready && (mem_stall_cnt_q != 16'hFFFF)) begin
      mem_stall_cnt_d = mem_stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_stall_cnt_q <= 16'd0;
      mem_stall_cnt_q <= 16'd0;
    end else begin
      alu_stall_cnt_q <= alu_stall_cnt_d;
      mem_stall_cnt_q <= mem_stall_cnt_d;
    end
  end

  assign alu_stall_cnt = alu_stall_cnt_q;
  assign mem_stall_cnt = mem_stall_cnt_q;
`else
  // Stall counters are not built in this configuration.
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter (XLEN=32, DEPTH=2); also checks stall counters when RF_WB_PERF_EN is defined.

module tb_rf_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, mem_valid;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_rd, mem_rd;
  logic [31:0] alu_data, mem_data;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        idle;
`ifdef RF_WB_PERF_EN
  logic [15:0] alu_stall_cnt, mem_stall_cnt;
`endif

  rf_wb_arbiter #(.XLEN(32), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .rf_we     (rf_we),
    .rf_wa     (rf_wa),
    .rf_wd     (rf_wd),
    .idle      (idle)
`ifdef RF_WB_PERF_EN
    ,
    .alu_stall_cnt (alu_stall_cnt),
    .mem_stall_cnt (mem_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [4:0]  wr_rd  [$];
  logic [31:0] wr_dat [$];
  int          wr_cyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rf_we) begin
      wr_rd.push_back(rf_wa);
      wr_dat.push_back(rf_wd);
      wr_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_rd.delete();
    wr_dat.delete();
    wr_cyc.delete();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
  endtask

  int  na, nm, stall_a, stall_m;
  logic acc_a, acc_m;
  logic [31:0] a_next, m_next;

  initial begin
    rst_n     = 1'b0;
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    alu_rd    = 5'd0;
    mem_rd    = 5'd0;
    alu_data  = 32'd0;
    mem_data  = 32'd0;

    // 1. reset state and release
    repeat (2) step();
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_alu_ready", alu_ready, 1'b0);
    chk("rst_mem_ready", mem_ready, 1'b0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_rf_wa", rf_wa, 5'd0);
    rst_n = 1'b1;
    step();
    chk("rel_alu_ready", alu_ready, 1'b1);
    chk("rel_mem_ready", mem_ready, 1'b1);

    // 2. single ALU write, two-edge latency, one-cycle pulse
    clear_log();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    step();
    alu_valid = 1'b0;
    chk("lat_we_k", rf_we, 1'b0);
    chk("lat_idle_k", idle, 1'b0);
    step();
    chk("lat_we_k1", rf_we, 1'b1);
    chk("lat_wa_k1", rf_wa, 5'd5);
    chk("lat_wd_k1", rf_wd, 32'hDEADBEEF);
    step();
    chk("lat_we_k2", rf_we, 1'b0);
    chk("lat_idle_k2", idle, 1'b1);
    chk("lat_nwrites", wr_rd.size(), 1);

    // 3/4. both sources push every cycle for 20 cycles after a fresh reset
    pulse_reset();
    clear_log();
    na = 0; nm = 0; stall_a = 0; stall_m = 0;
    a_next = 32'd1; m_next = 32'd100;
    alu_valid = 1'b1; alu_rd = 5'd1;
    mem_valid = 1'b1; mem_rd = 5'd2;
    for (int i = 0; i < 20; i++) begin
      alu_data = a_next;
      mem_data = m_next;
      acc_a = alu_ready;
      acc_m = mem_ready;
      if (!acc_a) stall_a++;
      if (!acc_m) stall_m++;
      step();
      if (acc_a) begin a_next++; na++; end
      if (acc_m) begin m_next++; nm++; end
    end
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    repeat (6) step();
    chk("rr_alu_accepts", na, 11);
    chk("rr_mem_accepts", nm, 11);
    chk("rr_alu_notready", stall_a, 9);
    chk("rr_mem_notready", stall_m, 9);
    chk("rr_nwrites", wr_rd.size(), 22);
    if (wr_rd.size() == 22) begin
      chk("rr_contiguous", wr_cyc[21] - wr_cyc[0], 21);
      for (int i = 0; i < 22; i++) begin
        chk($sformatf("rr_rd[%0d]", i), wr_rd[i], (i % 2 == 0) ? 5'd1 : 5'd2);
        chk($sformatf("rr_dat[%0d]", i), wr_dat[i],
            (i % 2 == 0) ? 32'(1 + i / 2) : 32'(100 + i / 2));
      end
    end
    chk("rr_idle", idle, 1'b1);
`ifdef RF_WB_PERF_EN
    chk("perf_alu_stall", alu_stall_cnt, 16'd9);
    chk("perf_mem_stall", mem_stall_cnt, 16'd9);
`endif

    // 5. x0 destination consumes a slot without writing
    clear_log();
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h12345678;
    step();
    mem_valid = 1'b0;
    chk("x0_idle_k", idle, 1'b0);
    step();
    chk("x0_we_k1", rf_we, 1'b0);
    chk("x0_idle_k1", idle, 1'b1);
    step();
    chk("x0_nwrites", wr_rd.size(), 0);

    // 6. reset mid-drain discards queued work
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA0;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'hB0;
    step();
    alu_data = 32'hA1; mem_data = 32'hB1;
    step();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    chk("mid_we_before", rf_we, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_we_async", rf_we, 1'b0);
    chk("mid_idle_async", idle, 1'b1);
    chk("mid_alu_ready", alu_ready, 1'b0);
    clear_log();
    #2;
    rst_n = 1'b1;
    repeat (6) step();
    chk("mid_nwrites", wr_rd.size(), 0);
    chk("mid_idle_after", idle, 1'b1);
    chk("mid_mem_ready", mem_ready, 1'b1);
`ifdef RF_WB_PERF_EN
    chk("perf_alu_clr", alu_stall_cnt, 16'd0);
    chk("perf_mem_clr", mem_stall_cnt, 16'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
